spi_master_arbiter: RTL and testbench
=====================================

Name: spi_master_arbiter

Overview:
- Shares one spi_master between N requesters using round-robin arbitration.
- Latches the granted requester's byte and mode config (cpol/cpha/divisor), sequences start/done on the master, and returns the received byte with a one-cycle ack.
- Drives per-requester active-low slave selects, gated by the master's ss_b.
- Sits between client logic and spi_master; it is the only driver of the master's start/config inputs.

Parameters:
- N, 4, number of requesters (2..8).
- DW, 8, transfer data width; matches spi_master.
- TIMEOUT, 4096, max clk cycles from start to done before abort.
- GAP, 2, idle clk cycles between consecutive transfers (0 allowed).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- req  in  N  per-requester level request, held until own ack
- req_data  in  N*DW  flat; slice i = byte to send for requester i
- cfg_cpol  in  N  per-requester clock polarity
- cfg_cpha  in  N  per-requester clock phase
- cfg_div  in  N*16  flat; slice i = sclk divisor for requester i
- ack  out  N  one-hot, one-cycle pulse on completion
- rsp_data  out  DW  received byte, valid with ack
- rsp_err  out  1  valid with ack; 1 = timeout or rejected config
- busy  out  1  transfer in progress (LAUNCH or WAIT)
- m_start  out  1  to spi_master start
- m_cpol, m_cpha  out  1  to spi_master
- m_divisor  out  16  to spi_master
- m_data_in  out  DW  to spi_master
- m_ready  in  1  spi_master idle
- m_done  in  1  spi_master completion pulse
- m_data_out  in  DW  spi_master received byte
- m_ss_b  in  1  spi_master slave select
- ss_n  out  N  per-slave select, active-low

Behaviour:
- Reset (rst=0, async): state IDLE, rr pointer=0, ack=0, rsp_data=0, rsp_err=0, busy=0, m_start=0, m_cpol=0, m_cpha=0, m_divisor=0, m_data_in=0, ss_n all 1.
- Reset mid-transfer aborts immediately with no ack; the requester's req stays pending and is re-arbitrated after reset release.
- IDLE: if any req is set, go to GRANT.
- GRANT (1 cycle):
  - Round-robin: search starts at index ptr and wraps; first set bit wins; ptr := winner+1 mod N.
  - Latch data, cpol, cpha and divisor of the winner into m_* registers.
  - If the latched divisor is 0, go to RESP with err=1 and no transfer.
  - Otherwise go to LAUNCH.
- LAUNCH: when m_ready=1, assert m_start=1 and go to WAIT. m_start stays high until m_done is seen.
- WAIT:
  - On m_done=1: latch m_data_out, drop m_start, go to RESP with err=0.
  - Cycle counter counts from LAUNCH exit. When it reaches TIMEOUT without m_done: drop m_start, go to RESP with err=1, rsp_data=0.
- RESP (1 cycle): ack[winner]=1 with rsp_data/rsp_err; then GAP if GAP>0, else IDLE.
- GAP: count GAP cycles, then IDLE.
- A req still high in the cycle after ack counts as a new request.
- ss_n[winner] = m_ss_b while in LAUNCH or WAIT; all other ss_n bits = 1 at all times.
- Config changes on cfg_* or req_data after GRANT have no effect on the current transfer.
- A req deasserted during a transfer is ignored; the transfer completes and ack still pulses.
- Master outputs are registered; the config is stable from GRANT through WAIT.
- Latency, single request from IDLE: req→m_start = 2 cycles when m_ready=1; m_done→ack = 1 cycle.

Decomposition:
- Shared package spi_pkg holds:
  - state encoding localparams (IDLE, GRANT, LAUNCH, WAIT, RESP, GAP)
  - DW default
  - divisor width (16)
- Sub-module rr_arbiter (params N): inputs req, ptr; outputs one-hot grant and grant index. Purely combinational; ptr update lives in the parent.

Test Plan:
- Single transfer: req[0]=1, data 8'hA5, cpol=0, cpha=0, div=4, master model returns 8'h3C → m_start high 2 cycles after req; ss_n[0] follows m_ss_b; ack[0] one cycle after m_done; rsp_data=8'h3C, rsp_err=0.
- Contention: req=4'b1111 held after reset → grant order 0,1,2,3,0; each transfer uses its own cfg (req2: cpol=1, cpha=1, div=8 shows on m_* during its transfer); GAP=2 idle cycles between transfers.
- Pointer wrap: ptr=3 after serving 2; req=4'b1001 → grant 3 then 0.
- Timeout: master never pulses m_done, TIMEOUT=16 → m_start drops 16 cycles after launch; ack with rsp_err=1, rsp_data=0; next request proceeds normally.
- Zero divisor: req[1] with div=0 → ack[1] with rsp_err=1 two cycles after req; m_start never asserted; ss_n stays 4'hF.
- Reset mid-transfer: rst=0 during WAIT → all outputs at reset values in the same cycle, no ack; after release with req[0] still high, transfer restarts and completes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and widths for the SPI master arbiter
package spi_pkg;

  localparam int DW_DEF = 8;
  localparam int DIV_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4,
    ST_GAP    = 3'd5
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter
  import spi_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  // walk the request vector from ptr with wrap; the first set bit wins
  always_comb begin
    logic found;
    int   idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - round-robin sharing of one spi_master between N clients
module spi_master_arbiter
  import spi_pkg::*;
#(
  parameter int N       = 4,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 4096,
  parameter int GAP     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*DW-1:0]      req_data,
  input  logic [N-1:0]         cfg_cpol,
  input  logic [N-1:0]         cfg_cpha,
  input  logic [N*DIV_W-1:0]   cfg_div,
  output logic [N-1:0]         ack,
  output logic [DW-1:0]        rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 m_start,
  output logic                 m_cpol,
  output logic                 m_cpha,
  output logic [DIV_W-1:0]     m_divisor,
  output logic [DW-1:0]        m_data_in,
  input  logic                 m_ready,
  input  logic                 m_done,
  input  logic [DW-1:0]        m_data_out,
  input  logic                 m_ss_b,
  output logic [N-1:0]         ss_n
);

  localparam int IW   = $clog2(N);
  localparam int CMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int CW   = $clog2(CMAX + 1);

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      win_q, win_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N-1:0]       ack_q, ack_d;
  logic [DW-1:0]      rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               m_start_q, m_start_d;
  logic               m_cpol_q, m_cpol_d;
  logic               m_cpha_q, m_cpha_d;
  logic [DIV_W-1:0]   m_div_q, m_div_d;
  logic [DW-1:0]      m_din_q, m_din_d;

  logic [N-1:0]       grant;
  logic [IW-1:0]      grant_idx;
  logic [DW-1:0]      sel_data;
  logic [DIV_W-1:0]   sel_div;
  logic [N-1:0]       win_oh;

  rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_rr (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign sel_data = req_data[int'(grant_idx)*DW +: DW];
  assign sel_div  = cfg_div[int'(grant_idx)*DIV_W +: DIV_W];

  // one-hot form of the latched winner, used for ack and slave select
  always_comb begin
    win_oh        = '0;
    win_oh[win_q] = 1'b1;
  end

  // sequence grant, launch, wait and response; all master-facing outputs are registered
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    m_start_d  = m_start_q;
    m_cpol_d   = m_cpol_q;
    m_cpha_d   = m_cpha_q;
    m_div_d    = m_div_q;
    m_din_d    = m_din_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (!(|req)) begin
          state_d = ST_IDLE;
        end else begin
          win_d    = grant_idx;
          ptr_d    = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
          m_din_d  = sel_data;
          m_cpol_d = cfg_cpol[grant_idx];
          m_cpha_d = cfg_cpha[grant_idx];
          m_div_d  = sel_div;
          if (sel_div == '0) begin
            // a zero divisor would never clock; reject without touching the master
            state_d    = ST_RESP;
            ack_d      = grant;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else begin
            state_d   = ST_LAUNCH;
            // raise start on the way in when the master is already idle
            m_start_d = m_ready;
          end
        end
      end
      ST_LAUNCH: begin
        if (m_start_q) begin
          cnt_d = '0;
          if (m_done) begin
            state_d    = ST_RESP;
            m_start_d  = 1'b0;
            ack_d      = win_oh;
            rsp_data_d = m_data_out;
            rsp_err_d  = 1'b0;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (m_ready) begin
          m_start_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (m_done) begin
          state_d    = ST_RESP;
          m_start_d  = 1'b0;
          ack_d      = win_oh;
          rsp_data_d = m_data_out;
          rsp_err_d  = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d    = ST_RESP;
          m_start_d  = 1'b0;
          ack_d      = win_oh;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        cnt_d   = '0;
        state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (cnt_q == CW'(GAP - 1)) state_d = ST_IDLE;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and output registers; reset aborts any transfer without an ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      m_start_q  <= 1'b0;
      m_cpol_q   <= 1'b0;
      m_cpha_q   <= 1'b0;
      m_div_q    <= '0;
      m_din_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      m_start_q  <= m_start_d;
      m_cpol_q   <= m_cpol_d;
      m_cpha_q   <= m_cpha_d;
      m_div_q    <= m_div_d;
      m_din_q    <= m_din_d;
    end
  end

  // only the winner's select follows the master, and only while a transfer is live
  always_comb begin
    ss_n = '1;
    if (state_q == ST_LAUNCH || state_q == ST_WAIT) ss_n[win_q] = m_ss_b;
  end

  assign busy      = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
  assign ack       = ack_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign m_start   = m_start_q;
  assign m_cpol    = m_cpol_q;
  assign m_cpha    = m_cpha_q;
  assign m_divisor = m_div_q;
  assign m_data_in = m_din_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb/tb_spi_master_arbiter.sv - scoreboard bench for spi_master_arbiter
module tb_spi_master_arbiter;

  localparam int N       = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;
  localparam int GAP     = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      cfg_cpol = '0;
  logic [N-1:0]      cfg_cpha = '0;
  logic [N*16-1:0]   cfg_div = '0;
  logic [N-1:0]      ack;
  logic [DW-1:0]     rsp_data;
  logic              rsp_err;
  logic              busy;
  logic              m_start;
  logic              m_cpol;
  logic              m_cpha;
  logic [15:0]       m_divisor;
  logic [DW-1:0]     m_data_in;
  logic              m_ready = 1'b1;
  logic              m_done = 1'b0;
  logic [DW-1:0]     m_data_out = '0;
  logic              m_ss_b = 1'b1;
  logic [N-1:0]      ss_n;

  spi_master_arbiter #(
    .N(N), .DW(DW), .TIMEOUT(TIMEOUT), .GAP(GAP)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_div(cfg_div),
    .ack(ack), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .m_start(m_start), .m_cpol(m_cpol), .m_cpha(m_cpha),
    .m_divisor(m_divisor), .m_data_in(m_data_in), .m_ready(m_ready),
    .m_done(m_done), .m_data_out(m_data_out), .m_ss_b(m_ss_b), .ss_n(ss_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       err;
    logic       hang;
    logic       zero;
    logic       first;
    logic       chk_tim;
    int         issue_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_ptr = 0;
  int   last_ack_cyc = 0;
  int   done_cyc = 0;
  int   last_lat = 0;
  bit   ovr_en = 1'b0;
  bit   scr_en = 1'b1;

  function automatic logic [7:0] slave_resp(logic [7:0] d, logic cp, logic ch, logic [15:0] dv);
    return ovr_en ? 8'h3C : (d ^ {cp, ch, dv[5:0]});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // external slave: responds after a random latency, hangs on byte 8'hEE, aborts when start drops
  int         mst_cnt = 0;
  bit         mst_busy = 1'b0;
  bit         mst_hang = 1'b0;
  logic [7:0] mst_resp = '0;
  always @(negedge clk) begin
    if (m_done) begin
      m_done  = 1'b0;
      m_ready = 1'b1;
    end else if (mst_busy) begin
      if (!m_start) begin
        mst_busy = 1'b0;
        m_ss_b   = 1'b1;
        m_ready  = 1'b1;
      end else if (!mst_hang) begin
        mst_cnt--;
        if (mst_cnt == 0) begin
          m_done     = 1'b1;
          m_data_out = mst_resp;
          m_ss_b     = 1'b1;
          mst_busy   = 1'b0;
          done_cyc   = cyc;
        end
      end
    end else if (m_start && m_ready) begin
      mst_hang = (m_data_in == 8'hEE) && !ovr_en;
      mst_resp = slave_resp(m_data_in, m_cpol, m_cpha, m_divisor);
      mst_cnt  = $urandom_range(1, 12);
      last_lat = mst_cnt;
      m_ready  = 1'b0;
      m_ss_b   = 1'b0;
      mst_busy = 1'b1;
    end
  end

  // monitor: slave-select rule every cycle, launch timing, and scoreboard pop on ack
  int         run = 0;
  logic       prev_start = 1'b0;
  exp_t       me;
  logic [N-1:0] ess;
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      run        = 0;
      prev_start = 1'b0;
    end else begin
      ess = '1;
      if (busy && exp_q.size() > 0) ess[exp_q[0].idx] = m_ss_b;
      check("ss_n", ss_n, ess);
      if (m_start && !prev_start && exp_q.size() > 0 && exp_q[0].chk_tim)
        check("start_latency", cyc,
              exp_q[0].first ? exp_q[0].issue_cyc + 2 : last_ack_cyc + GAP + 3);
      if (m_start) run++;
      if (ack != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", ack, 0);
        end else begin
          me = exp_q.pop_front();
          check("ack_onehot", ack, 1 << me.idx);
          check("rsp_data", rsp_data, me.data);
          check("rsp_err", rsp_err, me.err);
          if (me.zero) begin
            check("zero_div_no_start", run, 0);
            if (me.chk_tim)
              check("zero_div_latency", cyc,
                    me.first ? me.issue_cyc + 2 : last_ack_cyc + GAP + 3);
          end else if (me.hang) begin
            check("timeout_start_cycles", run, TIMEOUT + 1);
          end else begin
            check("start_cycles", run, last_lat + 1);
            check("done_to_ack", cyc - done_cyc, 1);
          end
        end
        last_ack_cyc = cyc;
        run = 0;
      end
      prev_start = m_start;
    end
  end

  task automatic scramble(input int i);
    req_data[i*DW +: DW] = 8'($urandom);
    cfg_cpol[i]          = 1'($urandom);
    cfg_cpha[i]          = 1'($urandom);
    cfg_div[i*16 +: 16]  = 16'($urandom);
  endtask

  task automatic step();
    @(negedge clk);
    req = req & ~ack;
    if (scr_en && busy && exp_q.size() > 0) scramble(exp_q[0].idx);
  endtask

  task automatic set_cfg(input int i, input logic [7:0] d, input logic cp, input logic ch,
                         input logic [15:0] dv);
    req_data[i*DW +: DW] = d;
    cfg_cpol[i]          = cp;
    cfg_cpha[i]          = ch;
    cfg_div[i*16 +: 16]  = dv;
  endtask

  // expected service order is a cyclic walk from the pointer over the requested set
  task automatic issue(input logic [N-1:0] set);
    bit first = 1'b1;
    int p = model_ptr;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (set[i]) begin
        exp_t e;
        logic [7:0]  d;
        logic [15:0] dv;
        d           = req_data[i*DW +: DW];
        dv          = cfg_div[i*16 +: 16];
        e.idx       = i;
        e.zero      = (dv == 16'd0);
        e.hang      = !e.zero && !ovr_en && (d == 8'hEE);
        e.err       = e.zero || e.hang;
        e.data      = e.err ? 8'h00 : slave_resp(d, cfg_cpol[i], cfg_cpha[i], dv);
        e.first     = first;
        e.chk_tim   = 1'b1;
        e.issue_cyc = cyc;
        exp_q.push_back(e);
        first     = 1'b0;
        model_ptr = (i + 1) % N;
      end
    end
    req = req | set;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      check("wait_bound_expired", exp_q.size(), 0);
      exp_q.delete();
      req = '0;
    end
    repeat (GAP + 2) step();
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {ack, busy, m_start, m_cpol, m_cpha, m_divisor, m_data_in, rsp_data, rsp_err, ss_n},
          45'hF);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    check_reset_outputs("reset_values");
    rst = 1'b1;
    repeat (2) step();

    ovr_en = 1'b1;
    set_cfg(0, 8'hA5, 1'b0, 1'b0, 16'd4);
    issue(4'b0001);
    wait_done(200);
    ovr_en = 1'b0;

    rst = 1'b0;
    step();
    rst = 1'b1;
    model_ptr = 0;
    step();
    set_cfg(0, 8'h11, 1'b0, 1'b0, 16'd3);
    set_cfg(1, 8'h22, 1'b0, 1'b1, 16'd5);
    set_cfg(2, 8'h33, 1'b1, 1'b1, 16'd8);
    set_cfg(3, 8'h44, 1'b1, 1'b0, 16'd2);
    issue(4'b1111);
    wait_done(400);
    issue(4'b0001);
    wait_done(200);

    issue(4'b0100);
    wait_done(200);
    issue(4'b1001);
    wait_done(300);

    set_cfg(1, 8'hEE, 1'b0, 1'b0, 16'd4);
    issue(4'b0010);
    wait_done(200);
    set_cfg(1, 8'h96, 1'b1, 1'b0, 16'd6);
    issue(4'b0010);
    wait_done(200);

    set_cfg(1, 8'h55, 1'b0, 1'b0, 16'd0);
    issue(4'b0010);
    wait_done(200);

    scr_en = 1'b0;
    set_cfg(0, 8'h5A, 1'b1, 1'b0, 16'd7);
    issue(4'b0001);
    for (int n = 0; n < 50 && !busy; n++) step();
    step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset_mid_transfer");
    if (exp_q.size() > 0) exp_q[0].chk_tim = 1'b0;
    step();
    check_reset_outputs("reset_held");
    rst = 1'b1;
    wait_done(200);
    scr_en = 1'b1;

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        logic [7:0]  d;
        logic [15:0] dv;
        d  = ($urandom_range(0, 9) == 0) ? 8'hEE : 8'($urandom);
        dv = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
        set_cfg(i, d, 1'($urandom), 1'($urandom), dv);
      end
      issue(4'($urandom_range(1, 15)));
      wait_done(400);
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
